// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-requester Wishbone arbiter.
// The round-robin tie option is controlled by WSHB_ARB_RR_EN in wshb_arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int REQ_VGA = 0;
    localparam int REQ_WR  = 1;

    // One-hot grant vector {req1, req0} for a given arbiter state.
    function automatic logic [1:0] gnt_of(arb_state_t s);
        logic [1:0] g;
        g          = 2'b00;
        g[REQ_VGA] = (s == GNT0);
        g[REQ_WR]  = (s == GNT1);
        return g;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic single-transfer Wishbone bundle shared by the frame reader,
// frame writer and the SDRAM controller port.
interface wshb_if #(
    parameter int DATA_W = 16,
    parameter int ADR_W  = 32
) ();

    logic [ADR_W-1:0]    adr;
    logic [DATA_W-1:0]   dat_ms;
    logic [DATA_W-1:0]   dat_sm;
    logic [DATA_W/8-1:0] sel;
    logic                we;
    logic                cyc;
    logic                stb;
    logic                ack;
    logic [2:0]          cti;
    logic [1:0]          bte;

    modport master (
        output adr, dat_ms, sel, we, cyc, stb, cti, bte,
        input  dat_sm, ack
    );

    modport slave (
        input  adr, dat_ms, sel, we, cyc, stb, cti, bte,
        output dat_sm, ack
    );

endinterface

// File: rtl/arb_quota_cnt.sv
// Counts consecutive acknowledged transfers of the granted requester while
// the other one waits; expire flags the last transfer of the quota.
module arb_quota_cnt #(
    parameter int MAX_HOLD = 64,
    parameter int HOLD_W   = $clog2(MAX_HOLD)
) (
    input  logic CLK,
    input  logic NRST,
    input  logic inc,
    input  logic clr,
    output logic expire
);

    // A quota of one still needs a one-bit register.
    localparam int            CW   = (HOLD_W < 1) ? 1 : HOLD_W;
    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/wshb_arbiter.sv
// Two-requester Wishbone arbiter for the shared SDRAM port with a per-grant
// transfer quota. Define WSHB_ARB_RR_EN for round-robin ties in IDLE.
//
// state | meaning
// IDLE  | no grant, master port driven to zero
// GNT0  | requester 0 (VGA reader) owns the master port
// GNT1  | requester 1 (frame writer) owns the master port
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int MAX_HOLD = 64,
    parameter int HOLD_W   = $clog2(MAX_HOLD)
) (
    input  logic       CLK,
    input  logic       NRST,
    wshb_if.slave      wshb_ifs_0,
    wshb_if.slave      wshb_ifs_1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] GNT
);

    arb_state_t state;
    arb_state_t state_nxt;

    logic req0;
    logic req1;
    logic sel0;
    logic sel1;
    logic req_other;
    logic tie_to_1;
    logic quota_inc;
    logic quota_clr;
    logic quota_expire;

    assign req0 = wshb_ifs_0.cyc & wshb_ifs_0.stb;
    assign req1 = wshb_ifs_1.cyc & wshb_ifs_1.stb;

    assign GNT  = gnt_of(state);
    assign sel0 = GNT[REQ_VGA];
    assign sel1 = GNT[REQ_WR];

    assign req_other = (sel0 & req1) | (sel1 & req0);

`ifdef WSHB_ARB_RR_EN
    logic last_gnt;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            last_gnt <= 1'b1;
        end else if (state_nxt != state) begin
            if (state_nxt == GNT0) begin
                last_gnt <= 1'b0;
            end else if (state_nxt == GNT1) begin
                last_gnt <= 1'b1;
            end
        end
    end

    assign tie_to_1 = ~last_gnt;
`else
    assign tie_to_1 = 1'b0;
`endif

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A falling cyc of the owner outranks quota expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = tie_to_1 ? GNT1 : GNT0;
                end else if (req0) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!wshb_ifs_0.cyc) begin
                    state_nxt = req1 ? GNT1 : IDLE;
                end else if (wshb_ifm.ack && req1 && quota_expire) begin
                    state_nxt = GNT1;
                end
            end
            GNT1: begin
                if (!wshb_ifs_1.cyc) begin
                    state_nxt = req0 ? GNT0 : IDLE;
                end else if (wshb_ifm.ack && req0 && quota_expire) begin
                    state_nxt = GNT0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign quota_inc = wshb_ifm.ack & req_other;
    assign quota_clr = (state_nxt != state) | ~req_other;

    arb_quota_cnt #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_quota (
        .CLK    (CLK),
        .NRST   (NRST),
        .inc    (quota_inc),
        .clr    (quota_clr),
        .expire (quota_expire)
    );

    assign wshb_ifm.adr    = sel0 ? wshb_ifs_0.adr    : (sel1 ? wshb_ifs_1.adr    : '0);
    assign wshb_ifm.dat_ms = sel0 ? wshb_ifs_0.dat_ms : (sel1 ? wshb_ifs_1.dat_ms : '0);
    assign wshb_ifm.sel    = sel0 ? wshb_ifs_0.sel    : (sel1 ? wshb_ifs_1.sel    : '0);
    assign wshb_ifm.we     = sel0 ? wshb_ifs_0.we     : (sel1 ? wshb_ifs_1.we     : 1'b0);
    assign wshb_ifm.cti    = sel0 ? wshb_ifs_0.cti    : (sel1 ? wshb_ifs_1.cti    : '0);
    assign wshb_ifm.bte    = sel0 ? wshb_ifs_0.bte    : (sel1 ? wshb_ifs_1.bte    : '0);
    assign wshb_ifm.cyc    = sel0 ? wshb_ifs_0.cyc    : (sel1 ? wshb_ifs_1.cyc    : 1'b0);
    assign wshb_ifm.stb    = sel0 ? wshb_ifs_0.stb    : (sel1 ? wshb_ifs_1.stb    : 1'b0);

    assign wshb_ifs_0.ack    = sel0 & wshb_ifm.ack;
    assign wshb_ifs_1.ack    = sel1 & wshb_ifm.ack;
    assign wshb_ifs_0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs_1.dat_sm = wshb_ifm.dat_sm;

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
Parameters:
- REQ-001 The block SHALL have parameter MAX_HOLD, default 64, meaning the maximum number of consecutive acknowledged transfers for one requester while the other requester is pending.
- REQ-002 The block SHALL have parameter HOLD_W, default $clog2(MAX_HOLD), meaning the width of the quota counter.

Ports:
- REQ-003 The block SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port NRST  input  1  reset, asynchronous and active-low.
- REQ-005 The block SHALL have port wshb_ifs_0  wshb_if.slave  bundle  requester 0, the VGA frame reader (highest tie priority).
- REQ-006 The block SHALL have port wshb_ifs_1  wshb_if.slave  bundle  requester 1, the frame writer.
- REQ-007 The block SHALL have port wshb_ifm  wshb_if.master  bundle  the shared SDRAM controller port.
- REQ-008 The block SHALL have port GNT  output  2  one-hot current grant, {req1, req0}; 2'b00 when idle.

Function
- REQ-009 Request i SHALL be defined as wshb_ifs_i.cyc & wshb_ifs_i.stb.
- REQ-010 The FSM SHALL have exactly three states: IDLE, GNT0, GNT1, held in a register.
- REQ-011 In IDLE, adr/dat_ms/sel/we/cti/bte/cyc/stb to wshb_ifm SHALL all be 0.
- REQ-012 In GNTi, all master-side signals SHALL be combinationally muxed from wshb_ifs_i.
- REQ-013 ack SHALL be routed only to the granted requester; the non-granted requester SHALL see ack=0.
- REQ-014 dat_sm SHALL be broadcast to both requesters.
- REQ-015 Arbitration latency SHALL be one cycle: a request seen in IDLE moves the FSM to GNTx at the next edge, and the first transfer is presented to wshb_ifm in that following cycle.
- REQ-016 In IDLE, if only one requester is active, the FSM SHALL grant that requester.
- REQ-017 In IDLE, if both requesters are active, the grant SHALL follow the tie rule of REQ-028/REQ-029.
- REQ-018 In GNTi, when wshb_ifs_i.cyc falls, the FSM SHALL go to GNTj if request j is active, else to IDLE.
- REQ-019 A 16-bit-agnostic quota counter SHALL increment on each wshb_ifm.ack in GNTi while request j is active.
- REQ-020 The quota counter SHALL clear on any state change, or when request j is inactive.
- REQ-021 When ack occurs with counter == MAX_HOLD-1 and request j active, the FSM SHALL switch to GNTj at that edge (preemption at a transfer boundary only; cti is always 0, single transfers).
- REQ-022 The preempted requester keeps its cyc/stb asserted and SHALL regain the grant per REQ-018/REQ-021; it never sees a spurious ack.
- REQ-023 A same-cycle ack and cyc fall of the granted requester SHALL complete that transfer and apply REQ-018.
- REQ-024 A same-cycle ack and quota expiry while cyc of the granted requester falls SHALL behave per REQ-018, which takes priority over REQ-021.
- REQ-025 GNT SHALL equal 2'b01 in GNT0, 2'b10 in GNT1, and 2'b00 in IDLE.

Reset
- REQ-026 On NRST low (asynchronous), the FSM SHALL enter IDLE, the quota counter SHALL clear, GNT SHALL be 2'b00, wshb_ifm cyc/stb SHALL be 0, and last-granted SHALL be set to 1.
- REQ-027 Reset assertion mid-transfer SHALL abandon that transfer; no ack SHALL be delivered to either requester until a new grant.

Configuration
- REQ-028 With macro WSHB_ARB_RR_EN defined, ties in IDLE SHALL go to the requester not granted last (round robin, last-granted register updated on each grant).
- REQ-029 Without WSHB_ARB_RR_EN, ties SHALL always go to requester 0; the last-granted register SHALL not be synthesized.
- REQ-030 Quota preemption (REQ-021) SHALL be active in both configurations.

Structure
- REQ-031 Package wshb_arb_pkg SHALL hold the state enum typedef (IDLE, GNT0, GNT1) and the requester index constants REQ_VGA=0 and REQ_WR=1.
- REQ-032 The quota counter SHALL be a sub-module, arb_quota_cnt (inputs: inc, clr, CLK, NRST; output: expire).

Verification
- REQ-033 Reset mid-GNT1 with ack pending -> GNT=00 and wshb_ifm.cyc=0 immediately; no ack to either requester.
- REQ-034 Only requester 1 requests, with 5 acks -> GNT=10 one cycle after the request, 5 acks delivered to requester 1, 0 to requester 0.
- REQ-035 MAX_HOLD=4, requester 0 holding cyc=1 permanently, requester 1 requests -> after the 4th ack, GNT=10 at the next edge; requester 1 is served 4 acks, then GNT=01.
- REQ-036 Both requesters request in IDLE after a requester-0 grant: with WSHB_ARB_RR_EN -> GNT=10; without it -> GNT=01.
- REQ-037 Granted requester 1 drops cyc in the same cycle as its last ack while requester 0 is pending -> the ack is delivered to requester 1 and GNT=01 at the next edge.
- REQ-038 Random stimulus from both requesters for 10k cycles -> a data-mux scoreboard shows every master-side field matches the granted requester, with no ack lost or duplicated.
